// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_pkg
//  Description : Shared constants for the two-port SRAM controller. It holds
//                the FSM state codes, the default strobe length and the
//                byte-lane to chip mapping that the board top level reuses.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    // Access sequencer state codes
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_SETUP  = 3'd1;
    localparam logic [2:0] c_ST_STROBE = 3'd2;
    localparam logic [2:0] c_ST_HOLD   = 3'd3;
    localparam logic [2:0] c_ST_ACK    = 3'd4;

    // Default strobe phase length in clocks (legal 1..15)
    localparam int c_WAIT_CYCLES_DEF = 2;

    // Byte-lane to chip mapping of sram_bsel_o
    localparam int c_BSEL_SRAM1_HI = 3;  // SRAM1[15:8]
    localparam int c_BSEL_SRAM1_LO = 2;  // SRAM1[7:0]
    localparam int c_BSEL_SRAM0_HI = 1;  // SRAM0[15:8]
    localparam int c_BSEL_SRAM0_LO = 0;  // SRAM0[7:0]

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : sram_rr_arb2
//  Description : Two-way round-robin grant logic. Purely combinational; the
//                parent owns and updates the last-granted pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    // A tie goes to the master that was not granted last
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_req == 2'b11) begin
                o_gnt = i_last ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Two-master Wishbone-classic controller for the 32-bit async
//                SRAM. Round-robin arbitration, then a setup / strobe / hold
//                sequence per access, with every output registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = c_WAIT_CYCLES_DEF
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [3:0]        m0_sel_i,
    input  logic [31:0]       m0_dat_i,
    output logic [31:0]       m0_dat_o,
    output logic              m0_ack_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [3:0]        m1_sel_i,
    input  logic [31:0]       m1_dat_i,
    output logic [31:0]       m1_dat_o,
    output logic              m1_ack_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_dat_o,
    input  logic [31:0]       sram_dat_i,
    output logic [3:0]        sram_bsel_o,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic              sram_we_o
);

    localparam logic [3:0] c_CNT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic              r_last;     // 1: m1 was granted last
    logic              r_gsel;     // 1: m1 owns the current access
    logic              r_alive;    // owner kept cyc up since grant
    logic              r_we_l;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_sel;
    logic [31:0]       r_wdat;
    logic [31:0]       r_rd_q;
    logic              r_cs;
    logic              r_oe;
    logic              r_we;
    logic              r_ack0;
    logic              r_ack1;
    logic [1:0]        w_gnt;
    logic              w_grant;
    logic              w_gcyc;
    logic              w_to_ack;

    sram_rr_arb2 u_arb (
        .i_req  ({m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i}),
        .i_last (r_last),
        .i_en   (r_state == c_ST_IDLE),
        .o_gnt  (w_gnt)
    );

    assign w_grant  = |w_gnt;
    assign w_gcyc   = r_gsel ? m1_cyc_i : m0_cyc_i;
    assign w_to_ack = (r_state == c_ST_HOLD);

    // Next-state decode of the access sequencer
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_grant) w_next = c_ST_SETUP;
            c_ST_SETUP:  w_next = c_ST_STROBE;
            c_ST_STROBE: if (r_cnt == 4'd0) w_next = c_ST_HOLD;
            c_ST_HOLD:   w_next = c_ST_ACK;
            c_ST_ACK:    w_next = c_ST_IDLE;
            default:     w_next = c_ST_IDLE;
        endcase
    end

    // State, latched request, counter and registered pin/ack outputs
    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_last  <= 1'b1;
            r_gsel  <= 1'b0;
            r_alive <= 1'b0;
            r_we_l  <= 1'b0;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_sel   <= 4'd0;
            r_wdat  <= 32'd0;
            r_rd_q  <= 32'd0;
            r_cs    <= 1'b0;
            r_oe    <= 1'b0;
            r_we    <= 1'b0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_gsel  <= w_gnt[1];
                r_alive <= 1'b1;
                r_we_l  <= w_gnt[1] ? m1_we_i  : m0_we_i;
                r_addr  <= w_gnt[1] ? m1_adr_i : m0_adr_i;
                r_sel   <= w_gnt[1] ? m1_sel_i : m0_sel_i;
                r_wdat  <= w_gnt[1] ? m1_dat_i : m0_dat_i;
            end else if (!w_gcyc) begin
                // a dropped cyc suppresses the ack but never aborts the cycle
                r_alive <= 1'b0;
            end
            if (r_state == c_ST_SETUP) begin
                r_cnt <= c_CNT_LOAD;
            end else if (r_state == c_ST_STROBE && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (r_state == c_ST_STROBE && r_cnt == 4'd0 && !r_we_l) begin
                r_rd_q <= sram_dat_i;
            end
            if (w_to_ack) begin
                r_last <= r_gsel;
            end
            r_cs   <= (w_next == c_ST_SETUP) || (w_next == c_ST_STROBE) || (w_next == c_ST_HOLD);
            r_oe   <= (w_next == c_ST_STROBE) && !r_we_l;
            r_we   <= (w_next == c_ST_STROBE) && r_we_l;
            r_ack0 <= w_to_ack && !r_gsel && r_alive && m0_cyc_i;
            r_ack1 <= w_to_ack &&  r_gsel && r_alive && m1_cyc_i;
        end
    end

    assign sram_addr_o = r_addr;
    assign sram_dat_o  = r_wdat;
    assign sram_bsel_o = r_sel;
    assign sram_cs_o   = r_cs;
    assign sram_oe_o   = r_oe;
    assign sram_we_o   = r_we;
    assign m0_ack_o    = r_ack0;
    assign m1_ack_o    = r_ack1;
    assign m0_dat_o    = r_rd_q;
    assign m1_dat_o    = r_rd_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Self-checking bench for sram_arbiter with an async SRAM model
//                and a transaction-level reference (memory array, round-robin
//                pointer and fixed latency rules).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk_50mhz = 1'b0;
    logic        reset;
    logic        m0_cyc, m0_stb, m0_we, m0_ack;
    logic [17:0] m0_adr;
    logic [3:0]  m0_sel;
    logic [31:0] m0_wdat, m0_rdat;
    logic        m1_cyc, m1_stb, m1_we, m1_ack;
    logic [17:0] m1_adr;
    logic [3:0]  m1_sel;
    logic [31:0] m1_wdat, m1_rdat;
    logic [17:0] sram_addr;
    logic [31:0] sram_dout;
    logic [31:0] sram_din;
    logic [3:0]  sram_bsel;
    logic        sram_cs, sram_oe, sram_we;

    // second instance built with a one-clock strobe
    logic        w1_cyc, w1_stb, w1_ack, w1_ack1, w1_cs, w1_oe, w1_we;
    logic [31:0] w1_rdat, w1_rdat1, w1_dout;
    logic [31:0] w1_din = 32'h1357_9BDF;
    logic [17:0] w1_addr;
    logic [3:0]  w1_bsel;

    int checks   = 0;
    int failures = 0;

    always #10 clk_50mhz = ~clk_50mhz;

    sram_arbiter #(.ADDR_W(18), .WAIT_CYCLES(2)) u_dut (
        .clk_50mhz(clk_50mhz), .reset(reset),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack),
        .sram_addr_o(sram_addr), .sram_dat_o(sram_dout), .sram_dat_i(sram_din),
        .sram_bsel_o(sram_bsel), .sram_cs_o(sram_cs), .sram_oe_o(sram_oe), .sram_we_o(sram_we)
    );

    sram_arbiter #(.ADDR_W(18), .WAIT_CYCLES(1)) u_dut_w1 (
        .clk_50mhz(clk_50mhz), .reset(reset),
        .m0_cyc_i(w1_cyc), .m0_stb_i(w1_stb), .m0_we_i(1'b0), .m0_adr_i(18'h5),
        .m0_sel_i(4'hF), .m0_dat_i(32'h0), .m0_dat_o(w1_rdat), .m0_ack_o(w1_ack),
        .m1_cyc_i(1'b0), .m1_stb_i(1'b0), .m1_we_i(1'b0), .m1_adr_i(18'h0),
        .m1_sel_i(4'h0), .m1_dat_i(32'h0), .m1_dat_o(w1_rdat1), .m1_ack_o(w1_ack1),
        .sram_addr_o(w1_addr), .sram_dat_o(w1_dout), .sram_dat_i(w1_din),
        .sram_bsel_o(w1_bsel), .sram_cs_o(w1_cs), .sram_oe_o(w1_oe), .sram_we_o(w1_we)
    );

    // ---------------- async SRAM model (byte lanes gated by bsel) ----------
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    logic        pre_en = 1'b0;
    logic [9:0]  pre_addr;
    logic [31:0] pre_dat;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

    // SRAM array writes and read data, settled mid-cycle
    always @(negedge clk_50mhz) begin
        if (pre_en) mem[pre_addr] <= pre_dat;
        else if (sram_cs && sram_we) mem[sram_addr[9:0]] <= merge(mem[sram_addr[9:0]], sram_dout, sram_bsel);
        sram_din <= (sram_cs && sram_oe) ? (mem[sram_addr[9:0]] & lane_mask(sram_bsel)) : 32'h0;
    end

    // ---------------- reference model state -------------------------------
    logic [31:0] ref_mem [0:1023];
    int          last_model;   // 1: m1 was granted last

    // ---------------- transaction driver / observer -----------------------
    int          ack_cyc [2];
    logic [31:0] ack_dat [2];
    int          order [$];
    int          oe_cnt, we_cnt, overlap_cnt, frame_bad, spur_cnt, cs_rise, ack_cs_bad;
    bit          timed_out;

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        pre_addr = a; pre_dat = d; pre_en = 1'b1;
        @(negedge clk_50mhz); #1;
        pre_en = 1'b0;
        ref_mem[a] = d;
        @(posedge clk_50mhz); #1;
    endtask

    task automatic do_xfer(input logic [1:0] req, input logic [1:0] wr,
                           input logic [17:0] a0, input logic [17:0] a1,
                           input logic [3:0] s0, input logic [3:0] s1,
                           input logic [31:0] d0, input logic [31:0] d1, input int abort_at);
        logic [1:0]  pend;
        int          cyc;
        logic        pcs, pwe;
        logic [17:0] paddr;
        logic [31:0] pdat;
        oe_cnt = 0; we_cnt = 0; overlap_cnt = 0; frame_bad = 0; spur_cnt = 0;
        cs_rise = 0; ack_cs_bad = 0; order.delete();
        ack_cyc[0] = -1; ack_cyc[1] = -1; ack_dat[0] = 'x; ack_dat[1] = 'x;
        m0_cyc = req[0]; m0_stb = req[0]; m0_we = wr[0]; m0_adr = a0; m0_sel = s0; m0_wdat = d0;
        m1_cyc = req[1]; m1_stb = req[1]; m1_we = wr[1]; m1_adr = a1; m1_sel = s1; m1_wdat = d1;
        pend = req; cyc = 0;
        pcs = sram_cs; pwe = sram_we; paddr = sram_addr; pdat = sram_dout;
        while ((pend != 2'b00 || sram_cs) && cyc < 60) begin
            @(posedge clk_50mhz); #1;
            cyc++;
            if (m0_ack) begin
                if (pend[0]) begin
                    pend[0] = 1'b0; ack_cyc[0] = cyc; ack_dat[0] = m0_rdat; order.push_back(0);
                    m0_cyc = 1'b0; m0_stb = 1'b0;
                end else spur_cnt++;
            end
            if (m1_ack) begin
                if (pend[1]) begin
                    pend[1] = 1'b0; ack_cyc[1] = cyc; ack_dat[1] = m1_rdat; order.push_back(1);
                    m1_cyc = 1'b0; m1_stb = 1'b0;
                end else spur_cnt++;
            end
            if (abort_at == cyc) begin
                m0_cyc = 1'b0; m0_stb = 1'b0; pend[0] = 1'b0;
            end
            if (sram_oe) oe_cnt++;
            if (sram_we) we_cnt++;
            if (sram_oe && sram_we) overlap_cnt++;
            if ((m0_ack || m1_ack) && sram_cs) ack_cs_bad++;
            if (sram_cs && !pcs) cs_rise++;
            if (sram_we && !pwe && !(pcs && sram_addr == paddr && sram_dout == pdat)) frame_bad++;
            if (!sram_we && pwe && !(sram_cs && sram_addr == paddr && sram_dout == pdat)) frame_bad++;
            pcs = sram_cs; pwe = sram_we; paddr = sram_addr; pdat = sram_dout;
        end
        timed_out = (pend != 2'b00) || sram_cs;
        @(posedge clk_50mhz); #1;
        if (m0_ack || m1_ack) spur_cnt++;
    endtask

    // ---------------- tests ------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk_50mhz);
        #1;
        checks++;
        if ({sram_cs, sram_oe, sram_we, sram_addr, sram_bsel, sram_dout, m0_ack, m1_ack, m0_rdat, m1_rdat} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: cs=%b oe=%b we=%b addr=%h bsel=%h dout=%h ack=%b%b rdat=%h/%h, all required 0",
                     sram_cs, sram_oe, sram_we, sram_addr, sram_bsel, sram_dout, m1_ack, m0_ack, m0_rdat, m1_rdat);
        end
        checks++;
        if ({w1_cs, w1_oe, w1_we, w1_addr, w1_bsel, w1_dout, w1_ack, w1_ack1, w1_rdat, w1_rdat1} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_w1: cs=%b oe=%b we=%b addr=%h rdat=%h, all required 0",
                     w1_cs, w1_oe, w1_we, w1_addr, w1_rdat);
        end
        reset = 1'b1;
        last_model = 1;
        @(posedge clk_50mhz); #1;
    endtask

    task automatic test_single_read();
        preload(10'h123, 32'hDEADBEEF);
        do_xfer(2'b01, 2'b00, 18'h123, 18'h0, 4'hF, 4'h0, 32'h0, 32'h0, -1);
        last_model = 0;
        checks++;
        if (ack_cyc[0] !== 5) begin failures++; $display("FAIL read_latency: ack cycle %0d, required 5", ack_cyc[0]); end
        checks++;
        if (ack_dat[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL read_data: got %h, required deadbeef", ack_dat[0]); end
        checks++;
        if (oe_cnt !== 2 || we_cnt !== 0) begin
            failures++; $display("FAIL read_strobes: oe clks %0d we clks %0d, required 2 and 0", oe_cnt, we_cnt);
        end
    endtask

    task automatic test_byte_write();
        do_xfer(2'b10, 2'b10, 18'h0, 18'h10, 4'h0, 4'b0100, 32'h0, 32'h11223344, -1);
        ref_mem[10'h10] = merge(ref_mem[10'h10], 32'h11223344, 4'b0100);
        last_model = 1;
        checks++;
        if (ack_cyc[1] !== 5 || ack_cyc[0] !== -1) begin
            failures++; $display("FAIL write_ack: m1 ack cycle %0d m0 %0d, required 5 and none", ack_cyc[1], ack_cyc[0]);
        end
        checks++;
        if (we_cnt !== 2 || frame_bad !== 0 || oe_cnt !== 0) begin
            failures++; $display("FAIL write_we_frame: we clks %0d unframed %0d oe clks %0d, required 2, 0, 0", we_cnt, frame_bad, oe_cnt);
        end
        do_xfer(2'b10, 2'b00, 18'h0, 18'h10, 4'h0, 4'hF, 32'h0, 32'h0, -1);
        checks++;
        if (ack_dat[1] !== 32'h00220000) begin failures++; $display("FAIL byte_readback: got %h, required 00220000", ack_dat[1]); end
    endtask

    task automatic test_contention();
        for (int k = 0; k < 2; k++) begin
            int          exp_first;
            logic [17:0] a [2];
            logic [31:0] d [2];
            logic [31:0] exp_rd [2];
            logic [1:0]  wr;
            a[0] = 18'h20 + 18'(k); a[1] = 18'h28 + 18'(k);
            d[0] = $urandom; d[1] = $urandom;
            wr = 2'($urandom_range(0, 3));
            exp_first = (last_model == 1) ? 0 : 1;
            do_xfer(2'b11, wr, a[0], a[1], 4'hF, 4'hF, d[0], d[1], -1);
            for (int j = 0; j < 2; j++) begin
                int m;
                m = (j == 0) ? exp_first : 1 - exp_first;
                exp_rd[m] = ref_mem[a[m][9:0]];
                if (wr[m]) ref_mem[a[m][9:0]] = d[m];
            end
            last_model = 1 - exp_first;
            checks++;
            if (order.size() != 2 || order[0] != exp_first || order[1] != 1 - exp_first) begin
                failures++; $display("FAIL contention_order[%0d]: %0d acks first m%0d, required m%0d then m%0d",
                                     k, order.size(), (order.size() > 0) ? order[0] : -1, exp_first, 1 - exp_first);
            end
            checks++;
            if (ack_cyc[exp_first] !== 5 || ack_cyc[1 - exp_first] !== 11) begin
                failures++; $display("FAIL contention_timing[%0d]: ack cycles %0d/%0d, required 5/11",
                                     k, ack_cyc[exp_first], ack_cyc[1 - exp_first]);
            end
            checks++;
            if (spur_cnt !== 0 || ack_cs_bad !== 0 || cs_rise !== 2 || overlap_cnt !== 0) begin
                failures++; $display("FAIL contention_bus[%0d]: spurious %0d cs-at-ack %0d accesses %0d overlap %0d, required 0,0,2,0",
                                     k, spur_cnt, ack_cs_bad, cs_rise, overlap_cnt);
            end
            for (int m = 0; m < 2; m++) begin
                if (!wr[m]) begin
                    checks++;
                    if (ack_dat[m] !== exp_rd[m]) begin
                        failures++; $display("FAIL contention_data[%0d] m%0d: got %h, required %h", k, m, ack_dat[m], exp_rd[m]);
                    end
                end
            end
        end
    endtask

    task automatic test_abort();
        do_xfer(2'b01, 2'b01, 18'h200, 18'h0, 4'hF, 4'h0, 32'hCAFEF00D, 32'h0, 3);
        ref_mem[10'h200] = 32'hCAFEF00D;
        last_model = 0;
        checks++;
        if (ack_cyc[0] !== -1 || spur_cnt !== 0) begin
            failures++; $display("FAIL abort_ack: ack cycle %0d spurious %0d, required none", ack_cyc[0], spur_cnt);
        end
        checks++;
        if (we_cnt !== 2 || timed_out) begin
            failures++; $display("FAIL abort_cycle: we clks %0d timeout %0d, required 2 and 0", we_cnt, timed_out);
        end
        checks++;
        if (mem[10'h200] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL abort_mem: sram holds %h, required cafef00d", mem[10'h200]);
        end
        do_xfer(2'b10, 2'b00, 18'h0, 18'h200, 4'h0, 4'hF, 32'h0, 32'h0, -1);
        last_model = 1;
        checks++;
        if (ack_cyc[1] !== 5 || ack_dat[1] !== 32'hCAFEF00D) begin
            failures++; $display("FAIL abort_recover: ack cycle %0d data %h, required 5 and cafef00d", ack_cyc[1], ack_dat[1]);
        end
    endtask

    task automatic test_reset_mid_write();
        // m0 completes an access so a tie would now favour m1 without reset
        do_xfer(2'b01, 2'b00, 18'h123, 18'h0, 4'hF, 4'h0, 32'h0, 32'h0, -1);
        last_model = 0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 18'h300; m0_sel = 4'hF; m0_wdat = 32'h12345678;
        repeat (3) @(posedge clk_50mhz);
        #1;
        checks++;
        if (sram_we !== 1'b1) begin failures++; $display("FAIL midwrite_strobe: we=%b, required 1", sram_we); end
        reset = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        @(posedge clk_50mhz); #1;
        checks++;
        if ({sram_cs, sram_oe, sram_we, sram_addr, sram_bsel, sram_dout, m0_ack, m1_ack, m0_rdat} !== '0) begin
            failures++; $display("FAIL midwrite_reset: cs=%b we=%b addr=%h dout=%h ack=%b%b rdat=%h, all required 0",
                                 sram_cs, sram_we, sram_addr, sram_dout, m1_ack, m0_ack, m0_rdat);
        end
        reset = 1'b1; last_model = 1;
        ref_mem[10'h300] = mem[10'h300];
        @(posedge clk_50mhz); #1;
        checks++;
        if (sram_cs !== 1'b0 || m0_ack !== 1'b0) begin
            failures++; $display("FAIL midwrite_idle: cs=%b ack=%b, required 0/0", sram_cs, m0_ack);
        end
        do_xfer(2'b11, 2'b00, 18'h123, 18'h10, 4'hF, 4'hF, 32'h0, 32'h0, -1);
        last_model = 1;
        checks++;
        if (order.size() != 2 || order[0] != 0 || ack_dat[0] !== ref_mem[10'h123]) begin
            failures++; $display("FAIL post_reset_tie: first m%0d data %h, required m0 and %h",
                                 (order.size() > 0) ? order[0] : -1, ack_dat[0], ref_mem[10'h123]);
        end
    endtask

    task automatic test_random();
        int bad_mem;
        for (int it = 0; it < 30; it++) begin
            logic [1:0]  req, wr;
            logic [17:0] a [2];
            logic [3:0]  s [2];
            logic [31:0] d [2];
            logic [31:0] exp_rd [2];
            int          seq [$];
            req = 2'($urandom_range(1, 3));
            wr  = 2'($urandom_range(0, 3));
            for (int m = 0; m < 2; m++) begin
                a[m] = 18'(32 + $urandom_range(0, 15));
                s[m] = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
                d[m] = $urandom;
            end
            if (req == 2'b11) begin
                seq.push_back((last_model == 1) ? 0 : 1);
                seq.push_back((last_model == 1) ? 1 : 0);
            end else seq.push_back(req[1] ? 1 : 0);
            foreach (seq[j]) begin
                exp_rd[seq[j]] = ref_mem[a[seq[j]][9:0]] & lane_mask(s[seq[j]]);
                if (wr[seq[j]]) ref_mem[a[seq[j]][9:0]] = merge(ref_mem[a[seq[j]][9:0]], d[seq[j]], s[seq[j]]);
                last_model = seq[j];
            end
            do_xfer(req, wr, a[0], a[1], s[0], s[1], d[0], d[1], -1);
            checks++;
            if (order != seq || timed_out || ack_cyc[seq[0]] !== 5) begin
                failures++; $display("FAIL random_order[%0d]: %0d acks first m%0d at cycle %0d timeout %0d, required m%0d at 5",
                                     it, order.size(), (order.size() > 0) ? order[0] : -1, ack_cyc[seq[0]], timed_out, seq[0]);
            end
            checks++;
            if (spur_cnt !== 0 || overlap_cnt !== 0 || frame_bad !== 0 || ack_cs_bad !== 0) begin
                failures++; $display("FAIL random_bus[%0d]: spurious %0d overlap %0d unframed %0d cs-at-ack %0d, required 0",
                                     it, spur_cnt, overlap_cnt, frame_bad, ack_cs_bad);
            end
            foreach (seq[j]) begin
                if (!wr[seq[j]]) begin
                    checks++;
                    if (ack_dat[seq[j]] !== exp_rd[seq[j]]) begin
                        failures++; $display("FAIL random_data[%0d] m%0d: got %h, required %h",
                                             it, seq[j], ack_dat[seq[j]], exp_rd[seq[j]]);
                    end
                end
            end
        end
        bad_mem = 0;
        for (int i = 32; i < 48; i++) if (mem[i] !== ref_mem[i]) bad_mem++;
        checks++;
        if (bad_mem != 0) begin failures++; $display("FAIL random_mem: %0d words differ, required 0", bad_mem); end
    endtask

    task automatic test_wait1();
        int cyc, ack_at, oe_n;
        logic [31:0] got;
        cyc = 0; ack_at = -1; oe_n = 0; got = 'x;
        w1_cyc = 1'b1; w1_stb = 1'b1;
        while (ack_at < 0 && cyc < 30) begin
            @(posedge clk_50mhz); #1;
            cyc++;
            if (w1_oe) oe_n++;
            if (w1_ack) begin ack_at = cyc; got = w1_rdat; w1_cyc = 1'b0; w1_stb = 1'b0; end
        end
        w1_cyc = 1'b0; w1_stb = 1'b0;
        checks++;
        if (ack_at !== 4 || oe_n !== 1) begin
            failures++; $display("FAIL wait1_timing: ack cycle %0d oe clks %0d, required 4 and 1", ack_at, oe_n);
        end
        checks++;
        if (got !== 32'h1357_9BDF) begin failures++; $display("FAIL wait1_data: got %h, required 13579bdf", got); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        reset = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_sel = '0; m0_wdat = '0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_sel = '0; m1_wdat = '0;
        w1_cyc = 1'b0; w1_stb = 1'b0;
        last_model = 1;
        @(posedge clk_50mhz); #1;
        test_reset();
        test_single_read();
        test_byte_write();
        test_contention();
        test_abort();
        test_reset_mid_write();
        test_random();
        test_wait1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
